// File: rtl/or1200_insn_sample_ctrl.sv
// Retired-instruction sampler: counts writeback toggles, issues a sample request every
// INTERVAL retirements over a req/ack handshake, and can freeze the CPU when samples back up.
module or1200_insn_sample_ctrl #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned PEND_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              insn_tgl,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  output logic              smp_req,
  input  logic              smp_ack,
  output logic [CNT_W-1:0]  smp_cnt,
  output logic              cpu_stall,
  output logic              irq
);

  localparam logic [PEND_W-1:0] PMAX    = '1;
  localparam logic [PEND_W-1:0] PMAX_M1 = PEND_W'((1 << PEND_W) - 2);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_e;

  state_e              state_q;
  logic                en_q, stall_en_q, ovf_q, tgl_prev_q;
  logic                smp_req_q, cpu_stall_q;
  logic [CNT_W-1:0]    interval_q, retired_q, icnt_q, smp_cnt_q;
  logic [PEND_W-1:0]   pend_q;

  logic                ret, evt, dec, ovf_evt, irq_clr;
  logic                wr_ctrl, wr_int, wr_ret;
  logic [CNT_W-1:0]    retired_d, icnt_d;
  logic [PEND_W-1:0]   pend_d;
  logic                ovf_d;
  logic [31:0]         status;

  // Retire detection, counters, pending bookkeeping
  always_comb begin
    ret       = insn_tgl ^ tgl_prev_q;
    wr_ctrl   = cfg_we && (cfg_addr == 2'd0);
    wr_int    = cfg_we && (cfg_addr == 2'd1);
    wr_ret    = cfg_we && (cfg_addr == 2'd2);
    irq_clr   = wr_ctrl && cfg_wdata[2];
    retired_d = retired_q;
    icnt_d    = icnt_q;
    evt       = 1'b0;
    if (en_q && ret) begin
      retired_d = retired_q + CNT_W'(1);
      if (interval_q != '0) begin
        if (icnt_q == interval_q - CNT_W'(1)) begin
          icnt_d = '0;
          evt    = 1'b1;
        end else begin
          icnt_d = icnt_q + CNT_W'(1);
        end
      end
    end
    if (wr_ret) retired_d = CNT_W'(cfg_wdata);
    if (wr_int) icnt_d = '0;

    dec     = (state_q == S_REQ) && smp_ack;
    ovf_evt = evt && !dec && (pend_q == PMAX);
    pend_d  = pend_q;
    if (evt && !dec && !ovf_evt) pend_d = pend_q + PEND_W'(1);
    else if (dec && !evt)        pend_d = pend_q - PEND_W'(1);
    // A fresh overflow outranks a same-cycle clear
    ovf_d   = ovf_evt || (ovf_q && !irq_clr);
  end

  // Register readback
  always_comb begin
    status              = '0;
    status[PEND_W-1:0]  = pend_q;
    status[8]           = ovf_q;
    status[9]           = (state_q != S_IDLE);
    case (cfg_addr)
      2'd0:    cfg_rdata = {30'd0, stall_en_q, en_q};
      2'd1:    cfg_rdata = 32'(interval_q);
      2'd2:    cfg_rdata = 32'(retired_q);
      default: cfg_rdata = status;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      en_q        <= 1'b0;
      stall_en_q  <= 1'b0;
      ovf_q       <= 1'b0;
      tgl_prev_q  <= 1'b0;
      smp_req_q   <= 1'b0;
      cpu_stall_q <= 1'b0;
      interval_q  <= '0;
      retired_q   <= '0;
      icnt_q      <= '0;
      smp_cnt_q   <= '0;
      pend_q      <= '0;
    end else begin
      tgl_prev_q  <= insn_tgl;
      if (wr_ctrl) begin
        en_q       <= cfg_wdata[0];
        stall_en_q <= cfg_wdata[1];
      end
      if (wr_int) interval_q <= CNT_W'(cfg_wdata);
      retired_q   <= retired_d;
      icnt_q      <= icnt_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      // Registered stall: one extra retirement may land after the threshold
      cpu_stall_q <= stall_en_q && (pend_q >= PMAX_M1);
      case (state_q)
        S_IDLE: begin
          if (pend_q != '0) begin
            state_q   <= S_REQ;
            smp_req_q <= 1'b1;
            smp_cnt_q <= retired_d;
          end
        end
        S_REQ: begin
          if (smp_ack) begin
            state_q   <= S_GAP;
            smp_req_q <= 1'b0;
          end
        end
        S_GAP: begin
          state_q   <= S_IDLE;
          smp_req_q <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          smp_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign smp_req   = smp_req_q;
  assign smp_cnt   = smp_cnt_q;
  assign cpu_stall = cpu_stall_q;
  assign irq       = ovf_q;

endmodule
